// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman window feeder: default geometry,
// fixed port widths and the feeder state type.
package huffman_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned WIN_WIDTH_DEF  = 10;
  localparam int unsigned BUF_WIDTH_DEF  = 64;

  // fill_level / symbolLength / statistics counter widths
  localparam int unsigned FILL_W  = 7;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned STATS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

  // Zero-extend a symbol length to the fill-level width.
  function automatic logic [FILL_W-1:0] len_to_fill(input logic [LEN_W-1:0] len);
    return FILL_W'(len);
  endfunction

endpackage

// File: rtl/huffman_window_feeder_if.sv
// Stream-in / window-out bundle of the Huffman window feeder.
// Optional macro FEEDER_STATS_EN adds the bits_consumed counter output.
interface huffman_window_feeder_if
  import huffman_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned WIN_WIDTH  = WIN_WIDTH_DEF
);

  // upstream word stream
  logic [WORD_WIDTH-1:0] in_word;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;

  // decoder side
  logic [WIN_WIDTH-1:0]  window;
  logic                  load;
  logic                  consume;
  logic [LEN_W-1:0]      symbolLength;

  // control / status
  logic                  flush;
  logic [FILL_W-1:0]     fill_level;
  logic                  done;
  logic                  err;

`ifdef FEEDER_STATS_EN
  logic [STATS_W-1:0]    bits_consumed;

  modport master (
    output in_word, in_valid, in_last, consume, symbolLength, flush,
    input  in_ready, window, load, fill_level, done, err, bits_consumed
  );

  modport slave (
    input  in_word, in_valid, in_last, consume, symbolLength, flush,
    output in_ready, window, load, fill_level, done, err, bits_consumed
  );
`else
  modport master (
    output in_word, in_valid, in_last, consume, symbolLength, flush,
    input  in_ready, window, load, fill_level, done, err
  );

  modport slave (
    input  in_word, in_valid, in_last, consume, symbolLength, flush,
    output in_ready, window, load, fill_level, done, err
  );
`endif

endinterface

// File: rtl/huffman_window_feeder_bit_merge.sv
// huffman_bit_merge: combinational next-buffer datapath of the feeder.
// The buffer is MSB-aligned: unconsumed bits sit at the top, everything
// below the fill level is zero. The buffer is shifted left by the consumed
// length and an accepted word is OR-ed in directly behind the remaining bits.
module huffman_bit_merge
  import huffman_pkg::*;
#(
  parameter int unsigned BUF_WIDTH  = BUF_WIDTH_DEF,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic [BUF_WIDTH-1:0]  i_buf,
  input  logic [FILL_W-1:0]     i_shift,
  input  logic [FILL_W-1:0]     i_pos,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic                  i_append,
  output logic [BUF_WIDTH-1:0]  o_buf
);

  logic [BUF_WIDTH-1:0] w_shifted;
  logic [BUF_WIDTH-1:0] w_word_ext;
  logic [BUF_WIDTH-1:0] w_placed;

  // Shift out consumed bits and place the new word at the post-shift fill level.
  // The caller guarantees i_pos <= BUF_WIDTH-WORD_WIDTH, so no word bit falls off.
  always_comb begin
    w_shifted  = i_buf << i_shift;
    w_word_ext = '0;
    w_word_ext[BUF_WIDTH-1 -: WORD_WIDTH] = i_word;
    w_placed   = w_word_ext >> i_pos;
    o_buf      = i_append ? (w_shifted | w_placed) : w_shifted;
  end

endmodule

// File: rtl/huffman_window_feeder.sv
// huffman_window_feeder: packs an MSB-first word stream into a bit buffer
// and presents a sliding window to a Huffman decoder, discarding
// symbolLength bits on each consume.
// Optional macro FEEDER_STATS_EN adds the 32-bit bits_consumed counter.
module huffman_window_feeder
  import huffman_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned WIN_WIDTH  = WIN_WIDTH_DEF,
  parameter int unsigned BUF_WIDTH  = BUF_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst,
  huffman_window_feeder_if.slave bus
);

  localparam logic [FILL_W-1:0] ACCEPT_MAX = FILL_W'(BUF_WIDTH - WORD_WIDTH);
  localparam logic [FILL_W-1:0] WIN_FILL   = FILL_W'(WIN_WIDTH);
  localparam logic [FILL_W-1:0] WORD_FILL  = FILL_W'(WORD_WIDTH);

  feeder_state_e         r_state;
  feeder_state_e         w_state_next;

  logic [BUF_WIDTH-1:0]  r_buf;
  logic [BUF_WIDTH-1:0]  w_buf_next;
  logic [FILL_W-1:0]     r_fill;
  logic                  r_err;

  logic                  w_in_ready;
  logic                  w_load;
  logic                  w_done;

  logic                  w_accept;
  logic [FILL_W-1:0]     w_len;
  logic                  w_cons_req;
  logic                  w_cons_ok;
  logic                  w_cons_bad;
  logic [FILL_W-1:0]     w_shift;
  logic [FILL_W-1:0]     w_fill_shifted;
  logic [FILL_W-1:0]     w_fill_next;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = bus.in_last ? ST_DRAIN : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_accept && bus.in_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_fill_next == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end
  end

  // State-derived outputs; in_ready is held low for as long as reset is asserted.
  always_comb begin
    w_in_ready = rst
              && ((r_state == ST_IDLE) || (r_state == ST_FILL))
              && (r_fill <= ACCEPT_MAX);
    w_load     = (r_fill >= WIN_FILL)
              || ((r_state == ST_DRAIN) && (r_fill != '0));
    w_done     = (r_state == ST_DONE);
  end

  // Accept / consume qualification and next fill level.
  always_comb begin
    w_accept       = bus.in_valid && w_in_ready;
    w_len          = len_to_fill(bus.symbolLength);
    w_cons_req     = bus.consume && (bus.symbolLength != '0);
    w_cons_ok      = w_cons_req && w_load
                  && (w_len <= WIN_FILL) && (w_len <= r_fill);
    w_cons_bad     = w_cons_req && !w_cons_ok;
    w_shift        = w_cons_ok ? w_len : '0;
    w_fill_shifted = r_fill - w_shift;
    w_fill_next    = w_fill_shifted + (w_accept ? WORD_FILL : '0);
  end

  huffman_bit_merge #(
    .BUF_WIDTH  (BUF_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_merge (
    .i_buf    (r_buf),
    .i_shift  (w_shift),
    .i_pos    (w_fill_shifted),
    .i_word   (bus.in_word),
    .i_append (w_accept),
    .o_buf    (w_buf_next)
  );

  // Bit buffer, fill level and sticky error; flush clears them synchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else if (bus.flush) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;
      r_err  <= r_err | w_cons_bad;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [STATS_W-1:0] r_bits_consumed;

  // Running total of bits discarded by valid consumes (wraps naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bits_consumed <= '0;
    end else if (bus.flush) begin
      r_bits_consumed <= '0;
    end else begin
      r_bits_consumed <= r_bits_consumed + STATS_W'(w_shift);
    end
  end

  assign bus.bits_consumed = r_bits_consumed;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.window     = r_buf[BUF_WIDTH-1 -: WIN_WIDTH];
  assign bus.load       = w_load;
  assign bus.fill_level = r_fill;
  assign bus.done       = w_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_huffman_window_feeder.sv
// Self-checking bench for huffman_window_feeder: directed scenarios followed
// by a randomized phase, all checked against a bit-queue reference model.
module tb_huffman_window_feeder;
  import huffman_pkg::*;

  localparam int unsigned WORD = WORD_WIDTH_DEF;
  localparam int unsigned WIN  = WIN_WIDTH_DEF;
  localparam int unsigned BUFW = BUF_WIDTH_DEF;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  huffman_window_feeder_if #(.WORD_WIDTH(WORD), .WIN_WIDTH(WIN)) bus ();

  huffman_window_feeder #(
    .WORD_WIDTH (WORD),
    .WIN_WIDTH  (WIN),
    .BUF_WIDTH  (BUFW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model: unconsumed bits in stream order
  bit          mq[$];
  int          m_st;
  bit          m_err;
  int unsigned m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  function automatic bit m_ready();
    return (rst === 1'b1) && (m_st == M_IDLE || m_st == M_FILL)
           && (mq.size() <= int'(BUFW - WORD));
  endfunction

  function automatic bit m_load();
    return (mq.size() >= int'(WIN)) || (m_st == M_DRAIN && mq.size() > 0);
  endfunction

  function automatic logic [WIN-1:0] m_window();
    logic [WIN-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WIN); i++) begin
      if (i < mq.size()) w[int'(WIN)-1-i] = mq[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_st  = M_IDLE;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_clock();
    bit acc, ld;
    int old, len;
    if (bus.flush) begin
      model_reset();
      return;
    end
    acc = bus.in_valid && m_ready();
    ld  = m_load();
    old = m_st;
    len = int'(bus.symbolLength);
    if (bus.consume && len != 0) begin
      if (ld && len <= int'(WIN) && len <= mq.size()) begin
        repeat (len) void'(mq.pop_front());
        m_cnt += len;
      end else begin
        m_err = 1'b1;
      end
    end
    if (acc) begin
      for (int i = int'(WORD) - 1; i >= 0; i--) mq.push_back(bus.in_word[i]);
      if (old == M_IDLE)       m_st = bus.in_last ? M_DRAIN : M_FILL;
      else if (bus.in_last)    m_st = M_DRAIN;
    end
    if (old == M_DRAIN && mq.size() == 0) m_st = M_DONE;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".fill"},     64'(bus.fill_level), 64'(mq.size()));
    chk({ph, ".window"},   64'(bus.window),     64'(m_window()));
    chk({ph, ".load"},     64'(bus.load),       64'(m_load()));
    chk({ph, ".in_ready"}, 64'(bus.in_ready),   64'(m_ready()));
    chk({ph, ".done"},     64'(bus.done),       64'(m_st == M_DONE));
    chk({ph, ".err"},      64'(bus.err),        64'(m_err));
`ifdef FEEDER_STATS_EN
    chk({ph, ".bits_consumed"}, 64'(bus.bits_consumed), 64'(m_cnt));
`endif
  endtask

  task automatic drive(input bit v, input logic [WORD-1:0] w, input bit last,
                       input bit c, input int unsigned len, input bit fl,
                       input string tag);
    bus.in_valid     = v;
    bus.in_word      = w;
    bus.in_last      = last;
    bus.consume      = c;
    bus.symbolLength = LEN_W'(len);
    bus.flush        = fl;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_word      = '0;
    bus.in_last      = 1'b0;
    bus.consume      = 1'b0;
    bus.symbolLength = '0;
    bus.flush        = 1'b0;
  endtask

  logic [WORD-1:0] lx, ly, lz;
  logic [WIN-1:0]  wv;
  logic [WIN-1:0]  seam;

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all("reset");
    chk("reset.in_ready_low", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("release");

    // single-word append
    drive(1, 32'hA5000000, 0, 0, 0, 0, "append");
    chk("append.fill_const",   64'(bus.fill_level), 64'd32);
    chk("append.window_const", 64'(bus.window),     64'(10'b1010010100));
    chk("append.load_const",   64'(bus.load),       64'd1);

    // mid-stream consume of 3
    drive(0, '0, 0, 1, 3, 0, "consume3");
    chk("consume3.fill_const",   64'(bus.fill_level), 64'd29);
    chk("consume3.window_const", 64'(bus.window),     64'(10'b0010100000));

    // simultaneous accept and consume across the seam
    drive(0, '0, 0, 0, 0, 1, "flush1");
    lx = $urandom();
    ly = $urandom();
    drive(1, lx, 0, 0, 0, 0, "seam.accept_x");
    drive(0, '0, 0, 1, 2, 0, "seam.consume2");
    chk("seam.fill30", 64'(bus.fill_level), 64'd30);
    drive(1, ly, 0, 1, 4, 0, "seam.accept_consume");
    chk("seam.fill58", 64'(bus.fill_level), 64'd58);
    drive(0, '0, 0, 1, 10, 0, "seam.c10a");
    drive(0, '0, 0, 1, 10, 0, "seam.c10b");
    seam = {lx[5:0], ly[31:28]};
    chk("seam.window_const", 64'(bus.window), 64'(seam));

    // drain with zero padding
    drive(0, '0, 0, 1, 10, 0, "drain.c10");
    lz = $urandom();
    drive(1, lz, 1, 0, 0, 0, "drain.last");
    chk("drain.in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) drive(0, '0, 0, 1, 10, 0, "drain.c10loop");
    drive(0, '0, 0, 1, 4, 0, "drain.c4");
    wv = bus.window;
    chk("drain.fill6",    64'(bus.fill_level), 64'd6);
    chk("drain.pad_zero", 64'(wv[3:0]),        64'd0);
    chk("drain.load6",    64'(bus.load),       64'd1);
    drive(0, '0, 0, 1, 6, 0, "drain.c6");
    chk("drain.done_const", 64'(bus.done), 64'd1);

    // protocol error then flush
    drive(0, '0, 0, 0, 0, 1, "err.flush0");
    drive(1, $urandom(), 0, 0, 0, 0, "err.accept");
    drive(0, '0, 0, 1, 12, 0, "err.bad_len");
    chk("err.err_const",  64'(bus.err),        64'd1);
    chk("err.fill_const", 64'(bus.fill_level), 64'd32);
    drive(0, '0, 0, 1, 0, 0, "err.zero_len");
    drive(0, '0, 0, 0, 0, 1, "err.flush");
    chk("err.cleared",    64'(bus.err),        64'd0);
    chk("err.fill_zero",  64'(bus.fill_level), 64'd0);
    chk("err.idle_ready", 64'(bus.in_ready),   64'd1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit v, last, c, fl;
      int unsigned len;
      v    = ($urandom_range(0, 99) < 60);
      last = ($urandom_range(0, 99) < 5);
      c    = ($urandom_range(0, 99) < 70);
      len  = ($urandom_range(0, 99) < 90) ? $urandom_range(1, 10) : $urandom_range(0, 15);
      fl   = (m_st == M_DONE) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 2);
      drive(v, $urandom(), last, c, len, fl, "rand");
    end

    // reset mid-stream at fill 40
    drive(0, '0, 0, 0, 0, 1, "rst.flush");
    drive(1, $urandom(), 0, 0, 0, 0, "rst.accept1");
    drive(0, '0, 0, 1, 10, 0, "rst.c10a");
    drive(0, '0, 0, 1, 10, 0, "rst.c10b");
    drive(0, '0, 0, 1, 4, 0, "rst.c4");
    drive(1, $urandom(), 0, 0, 0, 0, "rst.accept2");
    chk("rst.fill40", 64'(bus.fill_level), 64'd40);
    idle_inputs();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst.fill_zero",   64'(bus.fill_level), 64'd0);
    chk("rst.window_zero", 64'(bus.window),     64'd0);
    chk("rst.load_zero",   64'(bus.load),       64'd0);
    chk("rst.done_zero",   64'(bus.done),       64'd0);
    chk("rst.err_zero",    64'(bus.err),        64'd0);
    chk("rst.ready_zero",  64'(bus.in_ready),   64'd0);
`ifdef FEEDER_STATS_EN
    chk("rst.bits_consumed_zero", 64'(bus.bits_consumed), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    lx = $urandom();
    drive(1, lx, 0, 0, 0, 0, "rst.new_stream");
    chk("rst.new_fill", 64'(bus.fill_level), 64'd32);
    chk("rst.new_window", 64'(bus.window), 64'(lx[31:22]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
